ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. It sends command bytes (LED set 0xED, reset 0xFF, enable 0xF4, ...) to the keyboard over the same two-wire bus our PS/2 receiver listens on.
- Drives the open-drain clock and data lines through drive-low enables and frames one byte per request.
- Reports ACK or error to the controller that issues keyboard commands. It sits beside the receiver in the keyboard subsystem.

---
 rtl/ps2_pkg.sv | 37 +++
 rtl/ps2_line_sync.sv | 45 ++++
 rtl/ps2_host_tx.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 definitions for the keyboard subsystem. Holds the
//               host-transmit state encoding, frame geometry, common command
//               bytes and the odd-parity helper.
// Revision    : 1.0  initial release
// ============================================================================
package ps2_pkg;

    // Frame geometry
    localparam int PS2_DATA_BITS = 8;
    localparam int PS2_TX_FALLS  = 11;   // 8 data + parity + stop + ACK

    // Common keyboard command bytes
    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

    // Host-transmit FSM states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RELEASE   = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_tx_state_t;

    // Odd parity: the parity bit makes the total count of ones odd
    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : ps2_line_sync
// Description : Two-flop synchronizers for the PS/2 clock and data lines plus
//               a falling-edge detector on the synchronized clock. Shared by
//               the host transmitter and the receiver.
// Ports       : clk, rst          - system clock, synchronous active-high reset
//               i_ps2_clk/i_ps2_data - raw (asynchronous) line levels
//               o_clk_synced/o_data_synced - synchronized line levels
//               o_clk_fall         - one-cycle pulse on synced clock high->low
// Revision    : 1.0  initial release
// ============================================================================
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_clk_synced,
    output logic o_data_synced,
    output logic o_clk_fall
);

    logic [1:0] r_clk_sync;
    logic [1:0] r_data_sync;
    logic       r_clk_prev;

    // Reset to the idle-high bus level so leaving reset never fakes a fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    assign o_clk_synced  = r_clk_sync[1];
    assign o_data_synced = r_data_sync[1];
    assign o_clk_fall    = r_clk_prev & ~r_clk_sync[1];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : Host-to-device PS/2 transmitter. Inhibits the bus, issues a
//               start bit, shifts out one command byte (LSB first), odd parity
//               and stop on device clock falls, then samples the device ACK.
// Ports       : clk, rst            - system clock, synchronous active-high reset
//               tx_data/tx_valid/tx_ready - byte request handshake
//               ps2_clk/ps2_data    - sensed line levels (asynchronous)
//               ps2_clk_drive_low/ps2_data_drive_low - open-drain pull-downs
//               busy                - frame in progress
//               done/ack_err/timeout - one-cycle completion status pulses
// Config      : define PS2_TX_TIMEOUT_EN to build the device-clock watchdog;
//               otherwise timeout is tied low.
// Revision    : 1.0  initial release
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int                 c_INH_W      = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [c_INH_W-1:0] c_INH_LAST   = c_INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_INH_W-1:0] c_INH_ONE    = c_INH_W'(1);
    localparam logic [3:0]         c_PARITY_IDX = 4'(PS2_DATA_BITS);
    localparam logic [3:0]         c_STOP_IDX   = 4'(PS2_TX_FALLS - 2);

    ps2_tx_state_t      r_state;
    ps2_tx_state_t      w_next_state;
    logic [7:0]         r_byte;
    logic [c_INH_W-1:0] r_inh_cnt;
    logic [3:0]         r_fall_cnt;   // device falls seen so far in SEND
    logic               r_bit_low;    // data pull-down for the bit on the wire
    logic               r_hi_seen;    // bus seen idle on the previous cycle
    logic               r_done;
    logic               r_ack_err;
    logic               w_clk_s;
    logic               w_data_s;
    logic               w_fall;
    logic               w_parity;
    logic               w_wdog_expire;

    ps2_line_sync u_sync (
        .clk           (clk),
        .rst           (rst),
        .i_ps2_clk     (ps2_clk),
        .i_ps2_data    (ps2_data),
        .o_clk_synced  (w_clk_s),
        .o_data_synced (w_data_s),
        .o_clk_fall    (w_fall)
    );

    assign w_parity = ps2_odd_parity(r_byte);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. Falls outside SEND/ACK belong to device-to-host
    // traffic (or our own inhibit) and are ignored.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (tx_valid) w_next_state = INHIBIT;
            INHIBIT:   if (r_inh_cnt == c_INH_LAST) w_next_state = RELEASE;
            RELEASE:   w_next_state = w_wdog_expire ? WAIT_IDLE : SEND;
            SEND: begin
                if (w_wdog_expire)                         w_next_state = WAIT_IDLE;
                else if (w_fall && r_fall_cnt == c_STOP_IDX) w_next_state = ACK;
            end
            ACK:       if (w_fall || w_wdog_expire) w_next_state = WAIT_IDLE;
            WAIT_IDLE: if (w_clk_s && w_data_s && r_hi_seen) w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: byte latch, inhibit counter, bit sequencing, status pulses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte     <= 8'h00;
            r_inh_cnt  <= '0;
            r_fall_cnt <= 4'd0;
            r_bit_low  <= 1'b0;
            r_hi_seen  <= 1'b0;
            r_done     <= 1'b0;
            r_ack_err  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_inh_cnt <= '0;
                    r_hi_seen <= 1'b0;
                    if (tx_valid) r_byte <= tx_data;
                end
                INHIBIT: r_inh_cnt <= r_inh_cnt + c_INH_ONE;
                RELEASE: begin
                    r_fall_cnt <= 4'd0;
                    r_bit_low  <= 1'b1;       // keep the start bit on the wire
                end
                SEND: begin
                    if (w_fall) begin
                        r_fall_cnt <= r_fall_cnt + 4'd1;
                        if (r_fall_cnt < c_PARITY_IDX)
                            r_bit_low <= ~r_byte[r_fall_cnt[2:0]];
                        else if (r_fall_cnt == c_PARITY_IDX)
                            r_bit_low <= ~w_parity;
                        else
                            r_bit_low <= 1'b0; // stop bit: release data
                    end
                end
                ACK: begin
                    if (w_fall) begin
                        r_done    <= ~w_data_s;
                        r_ack_err <= w_data_s;
                    end
                end
                WAIT_IDLE: r_hi_seen <= w_clk_s & w_data_s;
                default: ;
            endcase
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // Device-clock watchdog: restarts on every fall, only runs while the
    // device owns the clock. Holding zero outside RELEASE/SEND/ACK gives the
    // clear on RELEASE entry for free.
    // ------------------------------------------------------------------------
    localparam int                  c_WDOG_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_ONE  = c_WDOG_W'(1);

    logic [c_WDOG_W-1:0] r_wdog;
    logic                r_timeout;
    logic                w_wdog_run;

    assign w_wdog_run    = (r_state == RELEASE) || (r_state == SEND) || (r_state == ACK);
    assign w_wdog_expire = w_wdog_run && !w_fall && (r_wdog == c_WDOG_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_wdog_expire;
            if (!w_wdog_run || w_fall) r_wdog <= '0;
            else                       r_wdog <= r_wdog + c_WDOG_ONE;
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_timeout_cfg;

    assign w_wdog_expire        = 1'b0;
    assign timeout              = 1'b0;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // ------------------------------------------------------------------------
    // Outputs. Line drives decode from registered state so reset releases
    // both lines on the first edge with rst high.
    // ------------------------------------------------------------------------
    always_comb begin
        tx_ready           = (r_state == IDLE);
        busy               = (r_state != IDLE);
        ps2_clk_drive_low  = (r_state == INHIBIT);
        ps2_data_drive_low = ((r_state == INHIBIT) && (r_inh_cnt == c_INH_LAST)) ||
                             (r_state == RELEASE) ||
                             ((r_state == SEND) && r_bit_low);
        done               = r_done;
        ack_err            = r_ack_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Directed self-checking bench for ps2_host_tx with a simple
//               open-drain bus and PS/2 keyboard model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int c_INHIBIT = 20;
    localparam int c_TIMEOUT = 100;
    localparam int c_HALF    = 8;     // device clock half-period in clk cycles

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_line;
    logic       ps2_data_line;
    logic       ps2_clk_drive_low;
    logic       ps2_data_drive_low;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;

    // Wired-AND open-drain bus with pull-ups
    assign ps2_clk_line  = ~(ps2_clk_drive_low | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_drive_low | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (c_INHIBIT),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .ps2_clk            (ps2_clk_line),
        .ps2_data           (ps2_data_line),
        .ps2_clk_drive_low  (ps2_clk_drive_low),
        .ps2_data_drive_low (ps2_data_drive_low),
        .busy               (busy),
        .done               (done),
        .ack_err            (ack_err),
        .timeout            (timeout)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_err   = 0;
    int n_tmo   = 0;

    int          inh_len;
    int          inh_data_at;
    logic        start_held;
    logic [10:0] frame_bits;

    always @(negedge clk) begin
        if (done === 1'b1)    n_done++;
        if (ack_err === 1'b1) n_err++;
        if (timeout === 1'b1) n_tmo++;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: observed running, expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Measures the inhibit phase; returns in the first cycle after clock release.
    task automatic wait_start();
        int t;
        t = 0;
        while (ps2_clk_drive_low !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        inh_len     = 0;
        inh_data_at = 0;
        while (ps2_clk_drive_low === 1'b1 && inh_len < 1000) begin
            inh_len++;
            if (ps2_data_drive_low === 1'b1 && inh_data_at == 0) inh_data_at = inh_len;
            @(negedge clk);
        end
        start_held = ps2_data_drive_low;
    endtask

    // One device clock pulse; the device samples data at its rising edge.
    task automatic dev_clock(output logic b);
        dev_clk_low = 1'b1;
        repeat (c_HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (c_HALF) @(negedge clk);
        b = ps2_data_line;
    endtask

    task automatic dev_ack(input logic ack_low);
        dev_data_low = ack_low;
        repeat (2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (c_HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (2) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (tx_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic dev_frame(input logic ack_low);
        logic b;
        wait_start();
        repeat (c_HALF) @(negedge clk);
        frame_bits[0] = ps2_data_line;
        for (int i = 1; i <= 10; i++) begin
            dev_clock(b);
            frame_bits[i] = b;
        end
        dev_ack(ack_low);
        wait_ready();
    endtask

    logic [7:0]  par_bytes [3];
    logic [10:0] par_frames[3];

    initial begin
        int d_done, d_err, d_tmo;
        int k, tmo_at;
        logic b;
        logic saw_drive;

        par_bytes[0] = 8'h00;  par_frames[0] = 11'h600;
        par_bytes[1] = 8'h01;  par_frames[1] = 11'h402;
        par_bytes[2] = 8'hFF;  par_frames[2] = 11'h7FE;

        rst      = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("reset_tx_ready", tx_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_drives", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
        check("reset_pulses", {done, ack_err, timeout}, 0);

        // 0xED with ACK, inhibit timing
        d_done = n_done; d_err = n_err;
        request(PS2_CMD_SET_LED);
        check("accept_busy", busy, 1);
        check("accept_tx_ready", tx_ready, 0);
        dev_frame(1'b1);
        check("inhibit_len", inhibit_len_value(), 20);
        check("inhibit_data_cycle", inh_data_at, 20);
        check("start_held_at_release", start_held, 1);
        check("frame_ED", frame_bits, 11'h7DA);
        check("ED_done", n_done - d_done, 1);
        check("ED_ack_err", n_err - d_err, 0);
        check("ED_tx_ready", tx_ready, 1);
        check("ED_busy", busy, 0);

        // Parity corners
        for (int i = 0; i < 3; i++) begin
            d_done = n_done;
            request(par_bytes[i]);
            dev_frame(1'b1);
            check($sformatf("frame_%02h", par_bytes[i]), frame_bits, par_frames[i]);
            check($sformatf("done_%02h", par_bytes[i]), n_done - d_done, 1);
        end

        // Device leaves data high at the ACK fall
        d_done = n_done; d_err = n_err;
        request(PS2_CMD_ENABLE);
        dev_frame(1'b0);
        check("nack_frame", frame_bits, 11'h5E8);
        check("nack_ack_err", n_err - d_err, 1);
        check("nack_done", n_done - d_done, 0);
        check("nack_tx_ready", tx_ready, 1);

        // Reset after fall 5 of a 0xF4 frame
        d_done = n_done; d_err = n_err; d_tmo = n_tmo;
        request(PS2_CMD_ENABLE);
        wait_start();
        repeat (c_HALF) @(negedge clk);
        for (int i = 1; i <= 5; i++) dev_clock(b);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_drives", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
        check("midrst_busy", busy, 0);
        check("midrst_tx_ready", tx_ready, 1);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_no_pulse", (n_done - d_done) + (n_err - d_err) + (n_tmo - d_tmo), 0);
        d_done = n_done;
        request(PS2_CMD_ENABLE);
        dev_frame(1'b1);
        check("after_rst_frame", frame_bits, 11'h5E8);
        check("after_rst_done", n_done - d_done, 1);

`ifdef PS2_TX_TIMEOUT_EN
        // Device never clocks after release
        d_done = n_done; d_err = n_err; d_tmo = n_tmo;
        request(PS2_CMD_RESET);
        wait_start();
        k = 0;
        tmo_at = -1;
        while (k < 300 && tmo_at < 0) begin
            if (k == 50) begin
                tx_data  = 8'h55;
                tx_valid = 1'b1;
            end
            if (k == 60) tx_valid = 1'b0;
            if (timeout === 1'b1) tmo_at = k;
            else begin
                @(negedge clk);
                k++;
            end
        end
        check("timeout_cycle", tmo_at, 100);
        check("timeout_drives", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
        wait_ready();
        saw_drive = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ps2_clk_drive_low === 1'b1 || busy === 1'b1) saw_drive = 1'b1;
            @(negedge clk);
        end
        check("busy_request_ignored", saw_drive, 0);
        check("timeout_pulses", n_tmo - d_tmo, 1);
        check("timeout_no_done", (n_done - d_done) + (n_err - d_err), 0);
`else
        // Without the watchdog the host waits for device clocks indefinitely
        d_tmo = n_tmo;
        request(PS2_CMD_RESET);
        wait_start();
        repeat (200) @(negedge clk);
        check("no_wdog_still_busy", busy, 1);
        check("no_wdog_timeout", n_tmo - d_tmo, 0);
        saw_drive = ps2_clk_drive_low;
        check("no_wdog_clk_released", saw_drive, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("no_wdog_recover_ready", tx_ready, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    function automatic int inhibit_len_value();
        return inh_len;
    endfunction

endmodule
`default_nettype wire
